// File: rtl/ptp_bridge_ipbb_pkg.sv
// Shared types for the store-and-forward read side of the PTP bridge:
// FIFO word control flags, framing FSM states and word field offsets.
package ptp_bridge_ipbb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DISC = 2'd2
  } rdr_state_e;

  // Control flags sit above {empty, data} in the FIFO word: {err, sop, eop}.
  typedef struct packed {
    logic err;
    logic sop;
    logic eop;
  } word_ctl_t;

  localparam int CTL_W = 3;

  function automatic int eop_off(input int dw, input int ew);
    return dw + ew;
  endfunction

  function automatic int sop_off(input int dw, input int ew);
    return dw + ew + 1;
  endfunction

  function automatic int err_off(input int dw, input int ew);
    return dw + ew + 2;
  endfunction

endpackage

// File: rtl/ptp_bridge_ipbb_sfw_rdr_if.sv
// Output beat stream of the store-and-forward reader.
interface ptp_bridge_ipbb_sfw_rdr_if #(
  parameter int DW = 64,
  parameter int EW = $clog2(DW/8)
);
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] tx_data;
  logic [EW-1:0] tx_empty;
  logic          tx_sop;
  logic          tx_eop;
  logic          tx_error;

  modport master (
    output tx_valid, tx_data, tx_empty, tx_sop, tx_eop, tx_error,
    input  tx_ready
  );

  modport slave (
    input  tx_valid, tx_data, tx_empty, tx_sop, tx_eop, tx_error,
    output tx_ready
  );
endinterface

// File: rtl/ptp_bridge_ipbb_sfw_rdr_buf.sv
// Two-entry in-order skid buffer between the FIFO read port and the tx stream.
module ptp_bridge_ipbb_sfw_rdr_buf #(
  parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_word,
   input  logic         pop,
   output logic [1:0]   occ,
   output logic [W-1:0] head
);

   logic [1:0][W-1:0] mem_q, mem_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        occ_q, occ_d;
   logic              do_pop;

   assign do_pop = pop & (occ_q != 2'd0);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_word;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_d = ~rd_ptr_q;
      occ_d = occ_q + {1'b0, push} - {1'b0, do_pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign occ  = occ_q;
   assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/ptp_bridge_ipbb_sfw_rdr.sv
// Store-and-forward FIFO reader: credit-based popping, framing check on each
// returning word, and a 2-entry output buffer feeding the tx beat stream.
module ptp_bridge_ipbb_sfw_rdr
  import ptp_bridge_ipbb_pkg::*;
#(
  parameter int DW = 64,
  parameter int EW = $clog2(DW/8),
  parameter int CW = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 fifo_empty,
   input  logic [DW+EW+2:0]     fifo_rdata,
   output logic                 fifo_pop,
   ptp_bridge_ipbb_sfw_rdr_if.master tx,
   output logic [CW-1:0]        pkt_cnt,
   output logic [CW-1:0]        drop_cnt,
   output logic                 frm_err
);

   typedef struct packed {
      word_ctl_t     ctl;
      logic [EW-1:0] empty;
      logic [DW-1:0] data;
   } fifo_word_t;

   localparam int WW = $bits(fifo_word_t);

   // Async assert, sync deassert; everything below runs off rst_sn.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_sn;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= rst_sync_d;
   end

   assign rst_sn = rst_sync_q[1];

   rdr_state_e    state_q, state_d;
   logic          inflight_q, inflight_d;
   logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic          frm_err_q, frm_err_d;

   fifo_word_t rword, push_word, head;
   logic       accept, force_err, viol, discard, push, deq;
   logic [1:0] occ;
   logic [2:0] credits;
   logic       tx_valid_i;

   assign rword = fifo_rdata;

   // Framing decision for the word returning this cycle.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      force_err = 1'b0;
      viol      = 1'b0;
      if (inflight_q) begin
         case (state_q)
            IDLE: begin
               if (rword.ctl.sop) begin
                  accept = 1'b1;
                  if (!rword.ctl.eop) state_d = PKT;
               end else begin
                  viol = 1'b1;
                  if (!rword.ctl.eop) state_d = DISC;
               end
            end
            PKT: begin
               accept = 1'b1;
               if (rword.ctl.sop) begin
                  force_err = 1'b1;
                  viol      = 1'b1;
                  state_d   = DISC;
               end else if (rword.ctl.eop) begin
                  state_d = IDLE;
               end
            end
            DISC: begin
               if (rword.ctl.eop) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign discard = inflight_q & ~accept;
   assign push    = inflight_q & accept;

   // A restarted packet closes the truncated one as an errored eop beat.
   always_comb begin
      push_word         = rword;
      push_word.ctl.err = rword.ctl.err | force_err;
      push_word.ctl.eop = rword.ctl.eop | force_err;
   end

   ptp_bridge_ipbb_sfw_rdr_buf #(.W(WW)) u_buf (
      .clk       (clk),
      .rst_n     (rst_sn),
      .push      (push),
      .push_word (push_word),
      .pop       (deq),
      .occ       (occ),
      .head      (head)
   );

   assign tx_valid_i = (occ != 2'd0);
   assign deq        = tx_valid_i & tx.tx_ready;

   // A discarded returning word gives its slot back immediately.
   assign credits  = {1'b0, occ} + {2'b00, push} - {2'b00, deq};
   assign fifo_pop = rst_sn & ~fifo_empty & (credits < 3'd2);

   always_comb begin
      inflight_d = fifo_pop;
      pkt_cnt_d  = pkt_cnt_q + CW'(deq & head.ctl.eop);
      drop_cnt_d = drop_cnt_q;
      if (discard && (drop_cnt_q != {CW{1'b1}})) drop_cnt_d = drop_cnt_q + 1'b1;
      frm_err_d  = viol;
   end

   always_ff @(posedge clk or negedge rst_sn) begin
      if (!rst_sn) begin
         state_q    <= IDLE;
         inflight_q <= 1'b0;
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
         frm_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         frm_err_q  <= frm_err_d;
      end
   end

   assign tx.tx_valid = tx_valid_i;
   assign tx.tx_data  = tx_valid_i ? head.data      : '0;
   assign tx.tx_empty = tx_valid_i ? head.empty     : '0;
   assign tx.tx_sop   = tx_valid_i & head.ctl.sop;
   assign tx.tx_eop   = tx_valid_i & head.ctl.eop;
   assign tx.tx_error = tx_valid_i & head.ctl.err;

   assign pkt_cnt  = pkt_cnt_q;
   assign drop_cnt = drop_cnt_q;
   assign frm_err  = frm_err_q;

endmodule
